// File: rtl/btn_conditioner.sv
// ---------------------------------------------------------------------------
// btn_conditioner
//   Conditions raw active-low push buttons into clean clk-domain events.
//   Per channel: 2-flop synchroniser, debounce FSM, registered one-cycle
//   press/release pulses, a debounced level and a one-shot long-press pulse.
//
// Ports
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   btn            in   [N_BTN] raw buttons, active-low, asynchronous to clk
//   level          out  [N_BTN] debounced state, 1 = pressed
//   press_pulse    out  [N_BTN] one-cycle pulse on accepted press
//   release_pulse  out  [N_BTN] one-cycle pulse on accepted release
//   long_pulse     out  [N_BTN] one-cycle pulse once per press after
//                                LONG_CYCLES held
// ---------------------------------------------------------------------------
module btn_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ZERO   = DB_W'(0);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED   = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_PRESSED    = 2'd2,
        ST_RELEASE_DB = 2'd3
    } state_t;

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;
    logic [N_BTN-1:0] w_raw_p;

    // Two-flop synchroniser; resets to "released" (button input high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= {N_BTN{1'b1}};
            r_sync2 <= {N_BTN{1'b1}};
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

    // Buttons are active-low; raw_p is the synchronised "pressed" view.
    assign w_raw_p = ~r_sync2;

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        state_t              r_state;
        state_t              w_state_nxt;
        logic [DB_W-1:0]     r_db_cnt;
        logic [DB_W-1:0]     w_db_cnt_nxt;
        logic [HOLD_W-1:0]   r_hold_cnt;
        logic [HOLD_W-1:0]   w_hold_cnt_nxt;
        logic                r_level;
        logic                w_level_nxt;
        logic                r_press;
        logic                w_press_nxt;
        logic                r_release;
        logic                w_release_nxt;
        logic                r_long;
        logic                w_long_nxt;
        logic                w_raw;

        assign w_raw = w_raw_p[g];

        // Debounce FSM state register.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= ST_RELEASED;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // Debounce FSM next-state logic.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_RELEASED: begin
                    if (w_raw) w_state_nxt = ST_PRESS_DB;
                    else       w_state_nxt = ST_RELEASED;
                end
                ST_PRESS_DB: begin
                    if (!w_raw)                  w_state_nxt = ST_RELEASED;
                    else if (r_db_cnt == DB_LAST) w_state_nxt = ST_PRESSED;
                    else                         w_state_nxt = ST_PRESS_DB;
                end
                ST_PRESSED: begin
                    if (!w_raw) w_state_nxt = ST_RELEASE_DB;
                    else        w_state_nxt = ST_PRESSED;
                end
                ST_RELEASE_DB: begin
                    if (w_raw)                   w_state_nxt = ST_PRESSED;
                    else if (r_db_cnt == DB_LAST) w_state_nxt = ST_RELEASED;
                    else                         w_state_nxt = ST_RELEASE_DB;
                end
                default: w_state_nxt = ST_RELEASED;
            endcase
        end

        // Counter and output next values; outputs are registered below so
        // each pulse appears in the cycle after the accepting edge.
        always_comb begin
            w_db_cnt_nxt   = r_db_cnt;
            w_hold_cnt_nxt = r_hold_cnt;
            w_level_nxt    = r_level;
            w_press_nxt    = 1'b0;
            w_release_nxt  = 1'b0;
            w_long_nxt     = 1'b0;
            case (r_state)
                ST_RELEASED: begin
                    w_db_cnt_nxt = DB_ZERO;
                end
                ST_PRESS_DB: begin
                    if (w_raw && (r_db_cnt == DB_LAST)) begin
                        w_db_cnt_nxt   = DB_ZERO;
                        w_hold_cnt_nxt = HOLD_ZERO;
                        w_level_nxt    = 1'b1;
                        w_press_nxt    = 1'b1;
                    end else if (w_raw) begin
                        w_db_cnt_nxt = r_db_cnt + DB_ONE;
                    end else begin
                        w_db_cnt_nxt = DB_ZERO;
                    end
                end
                ST_PRESSED: begin
                    // hold_cnt only advances while genuinely held, so a bounce
                    // through RELEASE_DB freezes it and long_pulse stays one-shot.
                    if (!w_raw) begin
                        w_db_cnt_nxt = DB_ZERO;
                    end else if (r_hold_cnt != HOLD_MAX) begin
                        w_hold_cnt_nxt = r_hold_cnt + HOLD_ONE;
                        w_long_nxt     = (r_hold_cnt == HOLD_PRE);
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt;
                    end
                end
                ST_RELEASE_DB: begin
                    if (!w_raw && (r_db_cnt == DB_LAST)) begin
                        w_db_cnt_nxt  = DB_ZERO;
                        w_level_nxt   = 1'b0;
                        w_release_nxt = 1'b1;
                    end else if (!w_raw) begin
                        w_db_cnt_nxt = r_db_cnt + DB_ONE;
                    end else begin
                        w_db_cnt_nxt = DB_ZERO;
                    end
                end
                default: begin
                    w_db_cnt_nxt = DB_ZERO;
                end
            endcase
        end

        // Counter and output registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_db_cnt   <= DB_ZERO;
                r_hold_cnt <= HOLD_ZERO;
                r_level    <= 1'b0;
                r_press    <= 1'b0;
                r_release  <= 1'b0;
                r_long     <= 1'b0;
            end else begin
                r_db_cnt   <= w_db_cnt_nxt;
                r_hold_cnt <= w_hold_cnt_nxt;
                r_level    <= w_level_nxt;
                r_press    <= w_press_nxt;
                r_release  <= w_release_nxt;
                r_long     <= w_long_nxt;
            end
        end

        assign level[g]         = r_level;
        assign press_pulse[g]   = r_press;
        assign release_pulse[g] = r_release;
        assign long_pulse[g]    = r_long;
    end

endmodule
